// File: rtl/data_io_ext.sv
// data_io_ext: receives download data from the IO controller over a
// three-wire serial link and writes it to RAM through a small write FIFO.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   sck, ss, sdi      serial link (async to clk), ss high = deselected
//   downloading       transfer active or FIFO still draining
//   index             last menu index received
//   wr, addr, data    RAM write request, held until ack
//   ack               RAM accepts the current write
//   size              bytes received in the current/last transfer
//   overflow          sticky: a word was dropped on a full FIFO
module data_io_ext #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 25,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BASE0 = 0,
    parameter int unsigned BASE1 = 'h380000,
    parameter int unsigned BASE2 = 'h3C0000,
    parameter int unsigned BASE3 = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sck,
    input  logic          ss,
    input  logic          sdi,
    output logic          downloading,
    output logic [4:0]    index,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    input  logic          ack,
    output logic [AW-1:0] size,
    output logic          overflow
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [7:0]  CMD_IDX  = 8'h55;
    localparam logic [7:0]  CMD_CTL  = 8'h53;
    localparam logic [7:0]  CMD_DAT  = 8'h54;

    // synchronisers; sck gets a third stage for rising-edge detection
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ss_meta_q, ss_sync_q;
    logic sdi_meta_q, sdi_sync_q;

    // serial receiver
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_q, cmd_d;
    logic       bit_en, byte_done, cmd_stb, payload_stb;
    logic [7:0] rx_byte;

    // transfer control
    logic          idx_done_q, idx_done_d;
    logic [4:0]    index_q, index_d;
    logic          active_q, active_d;
    logic [AW-1:0] size_q, size_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [7:0]    hold_q, hold_d;
    logic          odd_q, odd_d;
    logic          dl_q, dl_d;
    logic [AW-1:0] base_addr;
    logic          push, push_ok, start;
    logic [DW-1:0] push_word;

    // FIFO
    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];
    logic [PW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [PW:0]   count_q, count_d;
    logic          fifo_empty, fifo_full, pop;

    // RAM write port
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            ss_meta_q  <= 1'b0;
            ss_sync_q  <= 1'b0;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
        end else begin
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            ss_meta_q  <= ss;
            ss_sync_q  <= ss_meta_q;
            sdi_meta_q <= sdi;
            sdi_sync_q <= sdi_meta_q;
        end
    end

    assign bit_en      = sck_sync_q & ~sck_prev_q & ~ss_sync_q;
    assign byte_done   = bit_en & (bit_cnt_q == 3'd7);
    assign rx_byte     = {shreg_q, sdi_sync_q};
    assign cmd_stb     = byte_done & ~cmd_valid_q;
    assign payload_stb = byte_done & cmd_valid_q;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        if (ss_sync_q) begin
            // deselect discards any partial byte and rearms command capture
            bit_cnt_d   = '0;
            shreg_d     = '0;
            cmd_valid_d = 1'b0;
        end else if (bit_en) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {shreg_q[5:0], sdi_sync_q};
            if (cmd_stb) begin
                cmd_d       = rx_byte;
                cmd_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        case (index_q)
            5'd0:    base_addr = AW'(BASE0);
            5'd1:    base_addr = AW'(BASE1);
            5'd2:    base_addr = AW'(BASE2);
            5'd3:    base_addr = AW'(BASE3);
            default: base_addr = AW'(BASE0);
        endcase
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = wr_q & ack;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok    = push & (~fifo_full | pop);

    always_comb begin
        idx_done_d = idx_done_q;
        index_d    = index_q;
        active_d   = active_q;
        size_d     = size_q;
        ovf_d      = ovf_q;
        wptr_d     = wptr_q;
        hold_d     = hold_q;
        odd_d      = odd_q;
        dl_d       = dl_q;
        push       = 1'b0;
        push_word  = '0;
        start      = 1'b0;

        if (cmd_stb) begin
            idx_done_d = 1'b0;
        end

        if (payload_stb) begin
            case (cmd_q)
                CMD_IDX: begin
                    if (!idx_done_q) begin
                        index_d    = rx_byte[4:0];
                        idx_done_d = 1'b1;
                    end
                end
                CMD_CTL: begin
                    if (rx_byte[0]) begin
                        start    = 1'b1;
                        wptr_d   = base_addr;
                        size_d   = '0;
                        ovf_d    = 1'b0;
                        active_d = 1'b1;
                        dl_d     = 1'b1;
                        odd_d    = 1'b0;
                    end else begin
                        if (active_q && (DW == 16) && odd_q) begin
                            push      = 1'b1;
                            push_word = DW'({hold_q, 8'h00});
                        end
                        active_d = 1'b0;
                        odd_d    = 1'b0;
                    end
                end
                CMD_DAT: begin
                    if (active_q) begin
                        size_d = size_q + AW'(1);
                        if (DW == 8) begin
                            push      = 1'b1;
                            push_word = DW'(rx_byte);
                        end else if (!odd_q) begin
                            hold_d = rx_byte;
                            odd_d  = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_word = DW'({hold_q, rx_byte});
                            odd_d     = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // the pointer advances even when the word is dropped
        if (push) begin
            wptr_d = wptr_q + AW'(1);
            if (!push_ok) begin
                ovf_d = 1'b1;
            end
        end

        if (!start && dl_q && !active_q && fifo_empty && !wr_q) begin
            dl_d = 1'b0;
        end
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_idx_d = wr_idx_q + PW'(1);
        end
        if (pop) begin
            rd_idx_d = rd_idx_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // head entry stays in the FIFO while it is presented on wr/addr/data
    always_comb begin
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (wr_q) begin
            if (ack) begin
                wr_d = 1'b0;
            end
        end else if (!fifo_empty) begin
            wr_d   = 1'b1;
            addr_d = mem_addr_q[rd_idx_q];
            data_d = mem_data_q[rd_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr_q[wr_idx_q] <= wptr_q;
            mem_data_q[wr_idx_q] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            idx_done_q  <= 1'b0;
            index_q     <= '0;
            active_q    <= 1'b0;
            size_q      <= '0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            hold_q      <= '0;
            odd_q       <= 1'b0;
            dl_q        <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            count_q     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            idx_done_q  <= idx_done_d;
            index_q     <= index_d;
            active_q    <= active_d;
            size_q      <= size_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            hold_q      <= hold_d;
            odd_q       <= odd_d;
            dl_q        <= dl_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign downloading = dl_q;
    assign index       = index_q;
    assign wr          = wr_q;
    assign addr        = addr_q;
    assign data        = data_q;
    assign size        = size_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_data_io_ext.sv
// tb_data_io_ext: directed bench for data_io_ext. Two instances share the
// serial inputs: dut (DEPTH 8) and dut2 (DEPTH 2), each with its own ack.
module tb_data_io_ext;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        sdi = 1'b0;
    logic        ack = 1'b1;
    logic        ack2 = 1'b1;

    logic        dl1, wr1, ovf1;
    logic [4:0]  index1;
    logic [24:0] addr1, size1;
    logic [15:0] data1;
    logic        dl2, wr2, ovf2;
    logic [4:0]  index2;
    logic [24:0] addr2, size2;
    logic [15:0] data2;

    int n_vec = 0;
    int n_bad = 0;
    int ack_mode = 0;   // 0: always 1, 1: held 0, 2: pulse every 5th cycle
    int ack2_mode = 0;  // 0: always 1, 1: held 0
    int pulse_cnt = 0;
    int unstable = 0;

    typedef struct packed {
        logic [24:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t wq1[$];
    wr_t wq2[$];
    wr_t exp_q[$];

    typedef struct packed {
        logic [7:0]  cmd;
        logic [2:0]  n;
        logic [31:0] pl;
        logic [4:0]  exp_index;
        logic [24:0] exp_size;
        logic        exp_dl;
    } vec_t;

    vec_t tbl [18];

    data_io_ext #(.DW(16), .AW(25), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl1), .index(index1), .wr(wr1), .addr(addr1),
        .data(data1), .ack(ack), .size(size1), .overflow(ovf1)
    );

    data_io_ext #(.DW(16), .AW(25), .DEPTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl2), .index(index2), .wr(wr2), .addr(addr2),
        .data(data2), .ack(ack2), .size(size2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    // ack changes 2 ns after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            pulse_cnt = (pulse_cnt == 4) ? 0 : pulse_cnt + 1;
            if (ack_mode == 0) ack = 1'b1;
            else if (ack_mode == 1) ack = 1'b0;
            else ack = (pulse_cnt == 0);
            ack2 = (ack2_mode == 0);
        end
    end

    // write capture and hold-stability watch, sampled on the falling edge
    logic        p_wr = 1'b0, p_ack = 1'b0;
    logic [24:0] p_addr = '0;
    logic [15:0] p_data = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (p_wr && !p_ack && (wr1 !== 1'b1 || addr1 !== p_addr || data1 !== p_data))
                unstable++;
            if (p_wr && p_ack && wr1 !== 1'b0)
                unstable++;
            if (wr1 && ack) wq1.push_back({addr1, data1});
            if (wr2 && ack2) wq2.push_back({addr2, data2});
            p_wr = wr1;
        end else begin
            p_wr = 1'b0;
        end
        p_ack  = ack;
        p_addr = addr1;
        p_data = data1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_exp(input logic [24:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_wq(input string name, input int which);
        wr_t got[$];
        if (which == 1) got = wq1;
        else got = wq2;
        chk({name, ".count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s[%0d].addr", name, i), 64'(got[i].a), 64'(exp_q[i].a));
                chk($sformatf("%s[%0d].data", name, i), 64'(got[i].d), 64'(exp_q[i].d));
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int unsigned nb);
        logic [7:0] v;
        v = b;
        for (int unsigned i = 0; i < nb; i++) begin
            sdi = v[7];
            v = {v[6:0], 1'b0};
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic spi_start();
        @(negedge clk);
        ss = 1'b0;
        #80;
    endtask

    task automatic spi_stop();
        #40 ss = 1'b1;
        #120;
    endtask

    // pl holds n bytes right-aligned, sent first byte first
    task automatic spi_frame(input logic [7:0] cmd, input logic [2:0] n, input logic [31:0] pl);
        logic [31:0] p;
        p = pl << (8 * (4 - int'(n)));
        spi_start();
        spi_bits(cmd, 8);
        for (int unsigned k = 0; k < n; k++) begin
            spi_bits(p[31:24], 8);
            p = p << 8;
        end
        spi_stop();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".wr"},    64'(wr1),    64'(0));
        chk({tag, ".dl"},    64'(dl1),    64'(0));
        chk({tag, ".index"}, 64'(index1), 64'(0));
        chk({tag, ".addr"},  64'(addr1),  64'(0));
        chk({tag, ".data"},  64'(data1),  64'(0));
        chk({tag, ".size"},  64'(size1),  64'(0));
        chk({tag, ".ovf"},   64'(ovf1),   64'(0));
        chk({tag, ".wr2"},   64'(wr2),    64'(0));
        chk({tag, ".dl2"},   64'(dl2),    64'(0));
        chk({tag, ".ovf2"},  64'(ovf2),   64'(0));
    endtask

    initial begin
        //            cmd    n     payload       index  size   dl
        tbl[0]  = '{8'h55, 3'd1, 32'h01,       5'd1,  25'd0, 1'b0};
        tbl[1]  = '{8'h53, 3'd1, 32'h01,       5'd1,  25'd0, 1'b1};
        tbl[2]  = '{8'h54, 3'd4, 32'h12345678, 5'd1,  25'd4, 1'b1};
        tbl[3]  = '{8'h53, 3'd1, 32'h00,       5'd1,  25'd4, 1'b0};
        tbl[4]  = '{8'h55, 3'd1, 32'h00,       5'd0,  25'd4, 1'b0};
        tbl[5]  = '{8'h53, 3'd1, 32'h01,       5'd0,  25'd0, 1'b1};
        tbl[6]  = '{8'h54, 3'd3, 32'hAABBCC,   5'd0,  25'd3, 1'b1};
        tbl[7]  = '{8'h53, 3'd1, 32'h00,       5'd0,  25'd3, 1'b0};
        tbl[8]  = '{8'h54, 3'd1, 32'h11,       5'd0,  25'd3, 1'b0};
        tbl[9]  = '{8'h40, 3'd1, 32'h01,       5'd0,  25'd3, 1'b0};
        tbl[10] = '{8'h55, 3'd2, 32'h1F03,     5'd31, 25'd3, 1'b0};
        tbl[11] = '{8'h53, 3'd1, 32'h01,       5'd31, 25'd0, 1'b1};
        tbl[12] = '{8'h54, 3'd2, 32'hDEAD,     5'd31, 25'd2, 1'b1};
        tbl[13] = '{8'h53, 3'd1, 32'h00,       5'd31, 25'd2, 1'b0};
        tbl[14] = '{8'h55, 3'd1, 32'h02,       5'd2,  25'd2, 1'b0};
        tbl[15] = '{8'h53, 3'd1, 32'h01,       5'd2,  25'd0, 1'b1};
        tbl[16] = '{8'h54, 3'd2, 32'hC001,     5'd2,  25'd2, 1'b1};
        tbl[17] = '{8'h53, 3'd1, 32'h00,       5'd2,  25'd2, 1'b0};

        // reset state
        wait_clk(5);
        chk_reset_outputs("reset");
        @(negedge clk);
        #1 reset_n = 1'b1;
        wait_clk(5);

        // table: index/command/transfer sequences
        for (int i = 0; i < 18; i++) begin
            spi_frame(tbl[i].cmd, tbl[i].n, tbl[i].pl);
            wait_clk(20);
            chk($sformatf("v%0d.index", i), 64'(index1), 64'(tbl[i].exp_index));
            chk($sformatf("v%0d.size", i),  64'(size1),  64'(tbl[i].exp_size));
            chk($sformatf("v%0d.dl", i),    64'(dl1),    64'(tbl[i].exp_dl));
        end
        exp_q = {};
        add_exp(25'h380000, 16'h1234);
        add_exp(25'h380001, 16'h5678);
        add_exp(25'h000000, 16'hAABB);
        add_exp(25'h000001, 16'hCC00);
        add_exp(25'h000000, 16'hDEAD);
        add_exp(25'h3C0000, 16'hC001);
        chk_wq("tbl.writes", 1);

        // overflow on the DEPTH=2 instance with ack held low
        wq1 = {};
        wq2 = {};
        ack2_mode = 1;
        spi_frame(8'h55, 3'd1, 32'h00);
        spi_frame(8'h53, 3'd1, 32'h01);
        spi_frame(8'h54, 3'd4, 32'h01020304);
        spi_frame(8'h54, 3'd4, 32'h05060708);
        wait_clk(5);
        chk("ovf.flag2", 64'(ovf2),  64'(1));
        chk("ovf.wr2",   64'(wr2),   64'(1));
        chk("ovf.addr2", 64'(addr2), 64'(0));
        chk("ovf.data2", 64'(data2), 64'h0102);
        chk("ovf.flag1", 64'(ovf1),  64'(0));
        ack2_mode = 0;
        wait_clk(20);
        spi_frame(8'h54, 3'd2, 32'h090A);
        spi_frame(8'h53, 3'd1, 32'h00);
        wait_clk(20);
        chk("ovf.dl2",     64'(dl2),  64'(0));
        chk("ovf.sticky2", 64'(ovf2), 64'(1));
        exp_q = {};
        add_exp(25'd0, 16'h0102);
        add_exp(25'd1, 16'h0304);
        add_exp(25'd4, 16'h090A);
        chk_wq("ovf.writes2", 2);
        exp_q = {};
        add_exp(25'd0, 16'h0102);
        add_exp(25'd1, 16'h0304);
        add_exp(25'd2, 16'h0506);
        add_exp(25'd3, 16'h0708);
        add_exp(25'd4, 16'h090A);
        chk_wq("ovf.writes1", 1);
        spi_frame(8'h53, 3'd1, 32'h01);
        wait_clk(5);
        chk("ovf.cleared2", 64'(ovf2), 64'(0));
        chk("ovf.restart_dl2", 64'(dl2), 64'(1));
        spi_frame(8'h53, 3'd1, 32'h00);
        wait_clk(20);

        // ack pulsed every 5th cycle
        wq1 = {};
        unstable = 0;
        ack_mode = 2;
        spi_frame(8'h53, 3'd1, 32'h01);
        spi_frame(8'h54, 3'd4, 32'h10203040);
        spi_frame(8'h54, 3'd2, 32'h5060);
        spi_frame(8'h53, 3'd1, 32'h00);
        wait_clk(60);
        exp_q = {};
        add_exp(25'd0, 16'h1020);
        add_exp(25'd1, 16'h3040);
        add_exp(25'd2, 16'h5060);
        chk_wq("pulse.writes", 1);
        chk("pulse.stable", 64'(unstable), 64'(0));
        chk("pulse.dl", 64'(dl1), 64'(0));
        ack_mode = 0;
        wait_clk(10);

        // deselect after 5 bits of a data byte
        wq1 = {};
        spi_frame(8'h53, 3'd1, 32'h01);
        spi_start();
        spi_bits(8'h54, 8);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        spi_bits(8'h33, 5);
        spi_stop();
        wait_clk(10);
        chk("partial.size", 64'(size1), 64'(2));
        spi_frame(8'h54, 3'd2, 32'h3344);
        spi_frame(8'h53, 3'd1, 32'h00);
        wait_clk(20);
        chk("partial.size_end", 64'(size1), 64'(4));
        exp_q = {};
        add_exp(25'd0, 16'h1122);
        add_exp(25'd1, 16'h3344);
        chk_wq("partial.writes", 1);

        // reset with three entries queued
        wq1 = {};
        ack_mode = 1;
        spi_frame(8'h53, 3'd1, 32'h01);
        spi_frame(8'h54, 3'd4, 32'hA1A2B1B2);
        spi_frame(8'h54, 3'd2, 32'hC1C2);
        wait_clk(10);
        chk("rst.pre_wr", 64'(wr1), 64'(1));
        chk("rst.pre_dl", 64'(dl1), 64'(1));
        @(negedge clk);
        #1 reset_n = 1'b0;
        wait_clk(2);
        chk_reset_outputs("rst.mid");
        @(negedge clk);
        #1 reset_n = 1'b1;
        ack_mode = 0;
        wait_clk(50);
        chk("rst.no_writes", 64'(wq1.size()), 64'(0));
        chk("rst.post_wr", 64'(wr1), 64'(0));
        chk("rst.post_dl", 64'(dl1), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
